// File: rtl/dmem_responder.sv
// dmem_responder: word-organised byte-lane data-memory bank behind req/rsp valid-ready handshakes; optional DMEM_SCRUB_EN zero-fills the array after reset
module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = DM_ADDRESS - 2;
  localparam int DEPTH = 1 << IW;
`ifdef DMEM_SCRUB_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, SCRUB} state_t;
  localparam state_t RST_STATE = SCRUB;
  logic [IW-1:0] scrub_idx;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              l_we;
  logic [IW-1:0]     l_idx;
  logic [3:0]        l_be;
  logic [DATA_W-1:0] l_wdata;
  logic              be_ok, mem_we;
  logic [IW-1:0]     mem_idx;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_d;
  logic              addr_unused;
  assign addr_unused = ^req_addr[1:0];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST_STATE;
    else state <= nxt;
  // next-state: one transaction at a time, RESP waits for the requester
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = req_valid ? ACCESS : IDLE;
      ACCESS: nxt = RESP;
      RESP:   nxt = rsp_ready ? IDLE : RESP;
`ifdef DMEM_SCRUB_EN
      SCRUB:  nxt = (scrub_idx == IW'(DEPTH - 1)) ? IDLE : SCRUB;
`endif
      default: nxt = IDLE;
    endcase
  end
  // outputs and array write port; scrub borrows the port with an all-lanes zero write
  always_comb begin
    req_ready = (state == IDLE);
    be_ok = l_be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    mem_we = (state == ACCESS) && l_we && be_ok;
    mem_idx = l_idx;
    mem_be = l_be;
    mem_d = l_wdata;
`ifdef DMEM_SCRUB_EN
    mem_we = mem_we || (state == SCRUB);
    mem_idx = (state == SCRUB) ? scrub_idx : l_idx;
    mem_be = (state == SCRUB) ? 4'hF : l_be;
    mem_d = (state == SCRUB) ? '0 : l_wdata;
`endif
  end
`ifdef DMEM_SCRUB_EN
  // scrub pointer restarts from word 0 on every reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scrub_idx <= '0;
    else if (state == SCRUB) scrub_idx <= scrub_idx + IW'(1);
`endif
  // request latch and response registers; rsp_rdata keeps its value after the handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      l_we <= 1'b0;
      l_idx <= '0;
      l_be <= '0;
      l_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        l_we <= req_we;
        l_idx <= req_addr[DM_ADDRESS-1:2];
        l_be <= req_be;
        l_wdata <= req_wdata;
      end
      if (state == ACCESS) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= l_we ? '0 : mem[l_idx];
        rsp_err <= l_we && !be_ok;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err <= 1'b0;
      end
    end
  // storage is never reset; only enabled lanes are written
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_we && mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_d[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (scrub checks under DMEM_SCRUB_EN)
module tb_dmem_responder;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int          n_chk = 0, n_fail = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [4];
`ifdef DMEM_SCRUB_EN
  localparam logic SCRUB = 1'b1;
`else
  localparam logic SCRUB = 1'b0;
`endif
  always #5 clk = ~clk;
  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic legal(input logic [3:0] be);
    return be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000 ||
           be == 4'b0011 || be == 4'b1100 || be == 4'b1111;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 300) begin
      tick;
      n++;
    end
    check("ready_timeout", req_ready, 1);
  endtask
  task automatic xact(input logic we, input logic [8:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input int hold);
    logic [32:0] e;
    logic [31:0] held;
    int n;
    exp_q.push_back({ee, er});
    wait_ready(n);
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd; rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    check("access_no_valid", rsp_valid, 0);
    tick;
    check("rsp_valid_lat2", rsp_valid, 1);
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      tick;
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    check(we ? "st_rdata" : "ld_rdata", rsp_rdata, e[31:0]);
    check(we ? "st_err" : "ld_err", rsp_err, e[32]);
    tick;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [1:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    #3;
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ready", req_ready, !SCRUB);
    tick; tick;
    rst_n = 1'b1;
    if (SCRUB) begin
      wait_ready(n);
      check("scrub_cycles", n, 128);
      xact(0, 9'h1FC, 4'h0, 0, 32'h0, 0, 0);
    end
    xact(1, 9'h010, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    xact(0, 9'h010, 4'h0, 0, 32'hDEADBEEF, 0, 0);
    xact(1, 9'h010, 4'b0010, 32'h0000A500, 0, 0, 0);
    xact(0, 9'h013, 4'h0, 0, 32'hDEADA5EF, 0, 0);
    xact(1, 9'h010, 4'b1100, 32'h12340000, 0, 0, 0);
    xact(0, 9'h010, 4'hF, 0, 32'h1234A5EF, 0, 0);
    xact(1, 9'h010, 4'b0101, 32'hFFFFFFFF, 0, 1, 0);
    xact(0, 9'h010, 4'h0, 0, 32'h1234A5EF, 0, 0);
    xact(1, 9'h010, 4'b0000, 32'hFFFFFFFF, 0, 1, 0);
    xact(0, 9'h011, 4'h0, 0, 32'h1234A5EF, 0, 5);
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      xact(1, 9'(32'h40 + 4 * i), 4'hF, model[i], 0, 0, 0);
    end
    for (int i = 0; i < 12; i++) begin
      a = 2'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      xact(1, 9'(32'h40 + 4 * a + $urandom_range(0, 3)), be, wd, 0, !legal(be), 0);
      if (legal(be))
        for (int l = 0; l < 4; l++) if (be[l]) model[a][8*l +: 8] = wd[8*l +: 8];
    end
    for (int i = 0; i < 4; i++)
      xact(0, 9'(32'h40 + 4 * i + $urandom_range(0, 3)), 4'h0, 0, model[i], 0, 0);
    xact(1, 9'h020, 4'hF, 32'h11111111, 0, 0, 0);
    xact(0, 9'h020, 4'h0, 0, 32'h11111111, 0, 0);
    wait_ready(n);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_be = 4'hF; req_wdata = 32'hFFFFFFFF;
    tick;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_err", rsp_err, 0);
    check("mid_rst_ready", req_ready, !SCRUB);
    tick;
    rst_n = 1'b1;
    xact(0, 9'h020, 4'h0, 0, SCRUB ? 32'h0 : 32'h11111111, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-organised data-memory bank that serves load/store requests issued by the core's data-memory lane-steering logic. It accepts one request at a time over a valid/ready handshake, applies byte-lane write enables to the addressed word, returns full aligned read words over a second valid/ready handshake, and flags illegal lane patterns. It sits between the load/store unit and the physical storage. It is the responder end of the byte-enable memory interface.

## Interface

- DM_ADDRESS, 9, byte-address width; array depth is 2**(DM_ADDRESS-2) words
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  bank can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  DM_ADDRESS  byte address; word index = req_addr[DM_ADDRESS-1:2], bits [1:0] ignored
- req_be  input  4  byte-lane write enables, bit i = byte [8i+7:8i]; ignored for loads
- req_wdata  input  DATA_W  store data, already lane-positioned
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester takes the response
- rsp_rdata  output  DATA_W  full aligned word for loads; 0 for stores
- rsp_err  output  1  store rejected (illegal req_be)

## Operation

- FSM states: IDLE, ACCESS, RESP, plus SCRUB when DMEM_SCRUB_EN is defined.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/word index/be/wdata and go to ACCESS.
- ACCESS: req_ready=0. At the edge leaving ACCESS:
  - Load: rsp_rdata <= array[idx].
  - Store with legal be: write only the enabled lanes; rsp_rdata <= 0.
  - Store with illegal be: no array change; rsp_err <= 1.
  - Always go to RESP with rsp_valid <= 1.
- Legal store be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Every other pattern, including 0000, is illegal.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready. On that edge: rsp_valid <= 0, rsp_err <= 0, go to IDLE. rsp_rdata keeps its last value.
- Only one transaction is outstanding. Requests presented outside IDLE are not accepted and must be held by the requester.
- Array contents are not reset, except as stated under Configuration.

## Timing

- Reset (rst_n low, asynchronous): state IDLE (or SCRUB, see Configuration), rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 without the macro; req_ready=0 with it.
  - Latched request fields are cleared to 0.
- Latency: request accepted at edge E0; ACCESS for one cycle; rsp_valid high after edge E1. The response is therefore visible on the second cycle after the accept cycle.
- Throughput: with rsp_ready tied high, one transaction every 3 cycles.
- Read-after-write: a load accepted after a store's response handshake returns the merged word.
- Backpressure: rsp_ready low holds RESP indefinitely. req_ready stays 0 for the whole time.
- Reset mid-transaction: the transaction is discarded. A store still in ACCESS is not written. The response is dropped.
- Address wrap: the word index is DM_ADDRESS-2 bits, so there are no out-of-range addresses.

## Configuration

- DMEM_SCRUB_EN defined:
  - After reset deassertion the FSM is in SCRUB and writes 0 to one word per cycle, index 0 up to depth-1.
  - req_ready=0 throughout; the block enters IDLE on the cycle after the last word is written (depth cycles in total).
  - Reset during SCRUB restarts scrubbing from index 0.
- DMEM_SCRUB_EN undefined: there is no SCRUB state. IDLE is entered directly from reset, and array contents are undefined until written.

## Test plan

- Word store/load: store be=1111, addr=0x010, wdata=0xDEADBEEF, then load addr 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
- Byte-lane merge: after 0xDEADBEEF at 0x010, store be=0010 wdata=0x0000A500 -> load 0x013 returns 0xDEADA5EF. Then store be=1100 wdata=0x12340000 -> load returns 0x1234A5EF.
- Illegal be: store be=0101 to 0x010 -> rsp_err=1 for the response, rsp_rdata=0. A following load still returns 0x1234A5EF with rsp_err=0.
- Backpressure: load with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles, req_ready=0 with req_valid high. Raise rsp_ready -> one handshake, then req_ready=1 on the next cycle.
- Reset mid-store: assert rst_n low during ACCESS of a store of 0xFFFFFFFF be=1111 to 0x020 holding known 0x11111111 (no scrub) -> all outputs at reset values immediately, and a later load of 0x020 returns 0x11111111.
- Scrub (DMEM_SCRUB_EN): after reset, req_ready=0 for 128 cycles (DM_ADDRESS=9), then 1. A load of 0x1FC then returns 0x00000000.
